// File: rtl/alu_ctrl_dmem.sv
// alu_ctrl_dmem: instruction decode, 16-bit ALU with status flags and the
// 256x16 data memory of the multicycle RISC core. Decode and ALU are pure
// combinational logic; only the data memory holds state.
module alu_ctrl_dmem (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic [15:0] alu_a,
    input  logic [15:0] alu_b,
    input  logic [2:0]  alu_op_in,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    output logic [3:0]  op,
    output logic        reg_dst,
    output logic        ext_op,
    output logic        alu_src,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        reg_wr,
    output logic        branch,
    output logic        store,
    output logic        l_type,
    output logic        sv,
    output logic        jr,
    output logic [2:0]  alu_op,
    output logic [1:0]  wb_data,
    output logic [15:0] alu_result,
    output logic        zero,
    output logic        carry,
    output logic        overflow,
    output logic        negative,
    output logic [15:0] mem_rdata
);

    localparam logic [2:0] AluAnd  = 3'b000;
    localparam logic [2:0] AluAdd  = 3'b001;
    localparam logic [2:0] AluSub  = 3'b010;
    localparam logic [2:0] AluOr   = 3'b011;
    localparam logic [2:0] AluXor  = 3'b100;
    localparam logic [2:0] AluSll  = 3'b101;
    localparam logic [2:0] AluSrl  = 3'b110;

    logic [16:0]  aluWide;
    logic [7:0]   wordIdx;
    logic [15:0]  memWords_q [256];
    logic         unused_bits;

    // Only the word index bits select a word; the rest of the address and the
    // non-opcode instruction bits other than the R-type function are ignored.
    assign wordIdx     = mem_addr[8:1];
    assign unused_bits = ^{mem_addr[15:9], mem_addr[0], instr[11:2]};
    assign op          = instr[15:12];

    // Decode the opcode into datapath controls; everything defaults to 0 so
    // undefined opcodes behave as a NOP.
    always_comb begin
        reg_dst = 1'b0;
        ext_op  = 1'b0;
        alu_src = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        reg_wr  = 1'b0;
        branch  = 1'b0;
        store   = 1'b0;
        l_type  = 1'b0;
        sv      = 1'b0;
        jr      = 1'b0;
        alu_op  = 3'b000;
        wb_data = 2'b00;
        case (instr[15:12])
            4'b0000: begin
                reg_wr = 1'b1;
                alu_op = {1'b0, instr[1:0]};
            end
            4'b0010: begin
                alu_src = 1'b1;
                alu_op  = AluAnd;
                reg_wr  = 1'b1;
            end
            4'b0011: begin
                ext_op  = 1'b1;
                alu_src = 1'b1;
                alu_op  = AluAdd;
                reg_wr  = 1'b1;
            end
            4'b0100, 4'b0101: begin
                ext_op  = 1'b1;
                alu_src = 1'b1;
                alu_op  = AluAdd;
                mem_rd  = 1'b1;
                wb_data = 2'b01;
                reg_wr  = 1'b1;
                l_type  = ~instr[12];
            end
            4'b0111: begin
                ext_op  = 1'b1;
                alu_src = 1'b1;
                alu_op  = AluAdd;
                mem_wr  = 1'b1;
                store   = 1'b1;
            end
            4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
                ext_op = 1'b1;
                alu_op = AluSub;
                branch = 1'b1;
            end
            4'b1100, 4'b1110: begin
                jr = 1'b1;
            end
            4'b1101: begin
                jr      = 1'b1;
                reg_dst = 1'b1;
                reg_wr  = 1'b1;
                wb_data = 2'b10;
            end
            4'b1111: begin
                ext_op = 1'b1;
                sv     = 1'b1;
                mem_wr = 1'b1;
                store  = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU datapath; carry and overflow are only meaningful for ADD and SUB,
    // where SUB is done as a + ~b + 1 so carry=1 means no borrow.
    always_comb begin
        aluWide    = 17'd0;
        alu_result = 16'h0000;
        carry      = 1'b0;
        overflow   = 1'b0;
        case (alu_op_in)
            AluAnd: alu_result = alu_a & alu_b;
            AluAdd: begin
                aluWide    = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = aluWide[15:0];
                carry      = aluWide[16];
                overflow   = (alu_a[15] == alu_b[15]) && (aluWide[15] != alu_a[15]);
            end
            AluSub: begin
                aluWide    = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
                alu_result = aluWide[15:0];
                carry      = aluWide[16];
                overflow   = (alu_a[15] != alu_b[15]) && (aluWide[15] != alu_a[15]);
            end
            AluOr:  alu_result = alu_a | alu_b;
            AluXor: alu_result = alu_a ^ alu_b;
            AluSll: alu_result = alu_a << alu_b[3:0];
            AluSrl: alu_result = alu_a >> alu_b[3:0];
            default: alu_result = alu_b;
        endcase
    end

    assign zero     = (alu_result == 16'h0000);
    assign negative = alu_result[15];

    // Data memory: reset wipes every word in one edge and beats a same-cycle
    // write; otherwise a write lands at the addressed word on the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) begin
                memWords_q[i] <= 16'h0000;
            end
        end else if (mem_wr_en) begin
            memWords_q[wordIdx] <= mem_wdata;
        end
    end

    assign mem_rdata = mem_rd_en ? memWords_q[wordIdx] : 16'h0000;

endmodule

// File: tb/tb_alu_ctrl_dmem.sv
// tb_alu_ctrl_dmem: randomized and directed checks of decode, ALU and data
// memory against a behavioural reference model.
module tb_alu_ctrl_dmem;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op_in;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [3:0]  op;
    logic        reg_dst, ext_op, alu_src, mem_rd, mem_wr, reg_wr;
    logic        branch, store, l_type, sv, jr;
    logic [2:0]  alu_op;
    logic [1:0]  wb_data;
    logic [15:0] alu_result;
    logic        zero, carry, overflow, negative;
    logic [15:0] mem_rdata;

    int          vectors;
    int          miscompares;
    logic [15:0] refMem [256];

    alu_ctrl_dmem dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op_in  (alu_op_in),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .op         (op),
        .reg_dst    (reg_dst),
        .ext_op     (ext_op),
        .alu_src    (alu_src),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .reg_wr     (reg_wr),
        .branch     (branch),
        .store      (store),
        .l_type     (l_type),
        .sv         (sv),
        .jr         (jr),
        .alu_op     (alu_op),
        .wb_data    (wb_data),
        .alu_result (alu_result),
        .zero       (zero),
        .carry      (carry),
        .overflow   (overflow),
        .negative   (negative),
        .mem_rdata  (mem_rdata)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference ALU in integer arithmetic: returns {zero,carry,overflow,negative,result}.
    function automatic logic [19:0] refAlu(input logic [2:0] aop, input logic [15:0] a,
                                           input logic [15:0] b);
        int ua, ub, sa, sb, r, sr;
        logic c, v;
        logic [15:0] res;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        c = 1'b0; v = 1'b0; r = 0;
        case (aop)
            3'd0: r = ua & ub;
            3'd1: begin
                r = ua + ub; c = (r > 65535);
                sr = sa + sb; v = (sr > 32767) || (sr < -32768);
            end
            3'd2: begin
                r = ua - ub; c = (ua >= ub);
                sr = sa - sb; v = (sr > 32767) || (sr < -32768);
            end
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = ua << (ub % 16);
            3'd6: r = ua >> (ub % 16);
            default: r = ub;
        endcase
        res = 16'(r & 32'hFFFF);
        return {res == 16'h0000, c, v, res[15], res};
    endfunction

    // Reference decode table: returns {reg_dst,ext_op,alu_src,mem_rd,mem_wr,
    // reg_wr,branch,store,l_type,sv,jr,alu_op[2:0],wb_data[1:0]}.
    function automatic logic [15:0] refDecode(input logic [15:0] ins);
        logic rd, ex, as, mr, mw, rw, br, st, lt, s, j;
        logic [2:0] ao;
        logic [1:0] wb;
        int opc;
        {rd, ex, as, mr, mw, rw, br, st, lt, s, j} = '0;
        ao = 3'd0; wb = 2'd0;
        opc = int'(ins[15:12]);
        if (opc == 0) begin rw = 1; ao = 3'(ins[1:0]); end
        if (opc == 2) begin as = 1; rw = 1; end
        if (opc == 3) begin ex = 1; as = 1; ao = 3'd1; rw = 1; end
        if (opc == 4 || opc == 5) begin
            ex = 1; as = 1; ao = 3'd1; mr = 1; wb = 2'd1; rw = 1; lt = (opc == 4);
        end
        if (opc == 7) begin ex = 1; as = 1; ao = 3'd1; mw = 1; st = 1; end
        if (opc >= 8 && opc <= 11) begin ex = 1; ao = 3'd2; br = 1; end
        if (opc == 12 || opc == 14) j = 1;
        if (opc == 13) begin j = 1; rd = 1; rw = 1; wb = 2'd2; end
        if (opc == 15) begin ex = 1; s = 1; mw = 1; st = 1; end
        return {rd, ex, as, mr, mw, rw, br, st, lt, s, j, ao, wb};
    endfunction

    task automatic checkAlu(input logic [2:0] aop, input logic [15:0] a, input logic [15:0] b);
        logic [19:0] exp;
        alu_op_in = aop; alu_a = a; alu_b = b;
        #1;
        exp = refAlu(aop, a, b);
        checkOutput("alu_result", alu_result, exp[15:0]);
        checkOutput("alu_flags", {12'h0, zero, carry, overflow, negative}, {12'h0, exp[19:16]});
    endtask

    task automatic checkDecode(input logic [15:0] ins);
        instr = ins;
        #1;
        checkOutput("op", {12'h0, op}, {12'h0, ins[15:12]});
        checkOutput("decode", {reg_dst, ext_op, alu_src, mem_rd, mem_wr, reg_wr, branch,
                               store, l_type, sv, jr, alu_op, wb_data}, refDecode(ins));
    endtask

    // One memory cycle: drive on the falling edge, check the read before the
    // rising edge, then advance the model across the edge.
    task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic rdEn, input logic wrEn, input logic rstN);
        @(negedge clk);
        mem_addr = addr; mem_wdata = wdata; mem_rd_en = rdEn; mem_wr_en = wrEn; reset = rstN;
        #1;
        checkOutput("mem_rdata", mem_rdata, rdEn ? refMem[addr[8:1]] : 16'h0000);
        @(posedge clk);
        if (!rstN) begin
            for (int i = 0; i < 256; i++) refMem[i] = 16'h0000;
        end else if (wrEn) begin
            refMem[addr[8:1]] = wdata;
        end
    endtask

    initial begin
        logic [15:0] ra;
        vectors = 0; miscompares = 0;
        for (int i = 0; i < 256; i++) refMem[i] = 16'h0000;
        reset = 1'b0; instr = 16'h0; alu_a = 16'h0; alu_b = 16'h0; alu_op_in = 3'd0;
        mem_addr = 16'h0; mem_wdata = 16'h0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state: memory reads zero everywhere sampled.
        for (int i = 0; i < 8; i++) applyStimulus(16'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b1);

        // Directed ALU cases.
        checkAlu(3'd1, 16'h7FFF, 16'h0001);
        checkAlu(3'd1, 16'hFFFF, 16'h0001);
        checkAlu(3'd2, 16'h0003, 16'h0005);
        checkAlu(3'd2, 16'h8000, 16'h0001);
        checkAlu(3'd2, 16'h1234, 16'h1234);
        checkAlu(3'd0, 16'hF0F0, 16'h0FF0);
        checkAlu(3'd5, 16'h0001, 16'h0013);
        checkAlu(3'd6, 16'h8000, 16'h0004);
        checkAlu(3'd7, 16'h1111, 16'hABCD);
        // Randomized ALU sweep.
        for (int i = 0; i < 300; i++) checkAlu(3'($urandom), 16'($urandom), 16'($urandom));

        // Decode sweep over all opcodes, plus random instructions.
        for (int o = 0; o < 16; o++) begin
            for (int f = 0; f < 4; f++) checkDecode({4'(o), 10'($urandom), 2'(f)});
        end
        for (int i = 0; i < 100; i++) checkDecode(16'($urandom));

        // Directed memory: write/read, byte-offset and upper-bit aliasing, read disable.
        applyStimulus(16'h0010, 16'h1234, 1'b0, 1'b1, 1'b1);
        applyStimulus(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'h0011, 16'h0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'h0210, 16'h0000, 1'b1, 1'b0, 1'b1);
        // Read during write returns the old word, then the new one.
        applyStimulus(16'h0020, 16'hAAAA, 1'b0, 1'b1, 1'b1);
        applyStimulus(16'h0020, 16'h5555, 1'b1, 1'b1, 1'b1);
        applyStimulus(16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Reset clears filled words and drops a concurrent write.
        applyStimulus(16'h0000, 16'hDEAD, 1'b0, 1'b1, 1'b1);
        applyStimulus(16'h0002, 16'hBEEF, 1'b0, 1'b1, 1'b1);
        applyStimulus(16'h01FE, 16'hCAFE, 1'b0, 1'b1, 1'b1);
        applyStimulus(16'h0004, 16'h7777, 1'b1, 1'b1, 1'b0);
        applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'h0002, 16'h0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'h01FE, 16'h0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'h0004, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Random memory traffic over a small word pool with random alias bits.
        for (int i = 0; i < 500; i++) begin
            ra = (16'($urandom) & 16'hFE01) | (16'($urandom_range(0, 15)) << 1);
            applyStimulus(ra, 16'($urandom), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 49) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_dmem.md
# alu_ctrl_dmem

Execution and memory core of the 16-bit multicycle RISC processor. It decodes the current instruction into datapath control signals, performs 16-bit ALU operations with status flags, and holds the 256×16 data memory. Decode and ALU logic are combinational. Only the data memory is clocked. The surrounding datapath owns the PC, the register file, the stage registers and the FSM.

## Interface
- No parameters. Data memory is fixed at 256 words × 16 bits.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- instr  in  16  instruction to decode; opcode is instr[15:12].
- alu_a  in  16  ALU operand A.
- alu_b  in  16  ALU operand B.
- alu_op_in  in  3  ALU operation to perform.
- mem_addr  in  16  byte address for data memory.
- mem_wdata  in  16  write data for data memory.
- mem_rd_en  in  1  data memory read enable.
- mem_wr_en  in  1  data memory write enable.
- op  out  4  instr[15:12].
- reg_dst, ext_op, alu_src, mem_rd, mem_wr, reg_wr, branch, store, l_type, sv, jr  out  1 each  decoded control signals.
- alu_op  out  3  decoded ALU operation.
- wb_data  out  2  write-back source: 00 ALU, 01 memory, 10 return address.
- alu_result  out  16  ALU result.
- zero, carry, overflow, negative  out  1 each  ALU status flags.
- mem_rdata  out  16  data memory read data.

## Operation
- **ALU encoding:** 000 AND, 001 ADD, 010 SUB (a−b), 011 OR, 100 XOR, 101 SLL a by b[3:0], 110 SRL a by b[3:0], 111 pass b.
- **Width rules:** all arithmetic is 16-bit and wraps modulo 2^16.
- **zero and negative:** zero = (alu_result == 0); negative = alu_result[15].
- **carry:**
  - ADD: carry-out of bit 15.
  - SUB: carry-out of a + ~b + 1, so 1 means no borrow.
  - All other operations: 0.
- **overflow:** two's-complement signed overflow for ADD and SUB; 0 for all other operations.
- **Decode defaults:** every control output is 0 unless listed below.
  - 0000 R-type: reg_wr=1. alu_op follows instr[1:0]: 00→000, 01→001, 10→010, 11→011.
  - 0010 ANDI: alu_src=1, alu_op=000, reg_wr=1 (ext_op=0, zero-extend).
  - 0011 ADDI: ext_op=1, alu_src=1, alu_op=001, reg_wr=1.
  - 0100 LW: ext_op=1, alu_src=1, alu_op=001, mem_rd=1, wb_data=01, reg_wr=1, l_type=1.
  - 0101 LB: same as LW, but l_type=0.
  - 0111 SW: ext_op=1, alu_src=1, alu_op=001, mem_wr=1, store=1.
  - 1000–1011 branches: ext_op=1, alu_op=010, branch=1.
  - 1100 J: jr=1.
  - 1101 CALL: jr=1, reg_dst=1, reg_wr=1, wb_data=10.
  - 1110 RET: jr=1.
  - 1111 SV: ext_op=1, sv=1, mem_wr=1, store=1.
  - 0001 and 0110: undefined opcodes; all controls 0, which acts as a NOP.
- **Data memory addressing:** word index = mem_addr[8:1]. mem_addr[0] and mem_addr[15:9] are ignored.
- **Data memory read:** combinational. mem_rdata = mem[index] when mem_rd_en=1; otherwise 16'h0000.
- **Data memory write:** at the rising edge of clk when mem_wr_en=1 and reset=1, mem[index] ← mem_wdata.
- **Reset:** when reset=0 at a rising edge, all 256 words are cleared to 0 in that single cycle. Reset has priority over a simultaneous write.

## Timing
- Decode and ALU outputs are purely combinational. They settle within the same cycle, have no state and are not affected by reset.
- Data memory write latency is 1 edge. A read of the same word in the same cycle returns the old value; the new value is visible immediately after the edge.
- mem_rd_en and mem_wr_en may both be 1 in the same cycle; the read still returns pre-write data.
- Reset asserted mid-sequence discards any write in that cycle. After reset, mem_rdata reads 0 for every address.
- There are no handshakes. The caller holds inputs stable around the clock edge.

## Test plan
- **Arithmetic flags:**
  - ADD 7FFF+0001 → 8000, overflow=1, negative=1, carry=0.
  - ADD FFFF+0001 → 0000, zero=1, carry=1.
  - SUB 0003−0005 → FFFE, carry=0, negative=1.
- **Logic and shifts:**
  - AND F0F0&0FF0 → 00F0.
  - SLL 0001 by b=0013 → 0008 (only b[3:0] is used).
  - SRL 8000 by 0004 → 0800.
  - For all three: carry=0, overflow=0.
- **Decode sweep:** apply all 16 opcodes and check every control output against the table.
  - Example: instr=4xxx gives mem_rd=1, wb_data=01, l_type=1.
  - Example: instr=Dxxx gives jr=1, reg_dst=1, wb_data=10.
  - Opcodes 1 and 6 give all outputs 0.
- **Memory write/read:**
  - Write 1234 at addr 0010, then read addr 0010 and 0011 → both return 1234.
  - Read with mem_rd_en=0 → 0000.
  - Address 0210 aliases to 0010.
- **Read-during-write:** with addr 0020 holding AAAA, write 5555 to it. In the write cycle mem_rdata=AAAA; after the edge it is 5555.
- **Reset:**
  - Fill addr 0000, 0002 and 01FE with nonzero data.
  - Hold reset=0 for one edge while mem_wr_en=1. All three words then read 0000, and the concurrent write is dropped.
